// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: rotates a one-hot column drive, debounces the row
// response, and reports the accepted key as a code, a one-cycle strobe and a held level.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] posicion,
  output logic       key_strobe,
  output logic       key_valid
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]       fs_meta;
  logic [3:0]       fs;
  logic [DIV_W-1:0] div_cnt;
  logic             sample;

  logic [1:0]       state, state_nxt;
  logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
  logic [1:0]       cand_row, cand_row_nxt;
  logic [1:0]       cand_col, cand_col_nxt;
  logic [3:0]       col_nxt;
  logic [3:0]       posicion_nxt;
  logic             strobe_nxt;
  logic             valid_nxt;
  logic             row_hit;

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs_meta <= 4'b0000;
      fs      <= 4'b0000;
    end else begin
      fs_meta <= fila;
      fs      <= fs_meta;
    end
  end

  // Column dwell timer; the last count of each dwell is the sample event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (sample) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign sample  = (div_cnt == DIV_LAST);
  assign row_hit = fs[cand_row];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_SCAN;
      db_cnt     <= '0;
      cand_row   <= 2'd0;
      cand_col   <= 2'd0;
      col        <= 4'b0001;
      posicion   <= 4'd0;
      key_strobe <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      db_cnt     <= db_cnt_nxt;
      cand_row   <= cand_row_nxt;
      cand_col   <= cand_col_nxt;
      col        <= col_nxt;
      posicion   <= posicion_nxt;
      key_strobe <= strobe_nxt;
      key_valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    cand_row_nxt = cand_row;
    cand_col_nxt = cand_col;
    col_nxt      = col;
    posicion_nxt = posicion;
    strobe_nxt   = 1'b0;
    valid_nxt    = key_valid;

    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (fs == 4'b0000) begin
            col_nxt = {col[2:0], col[3]};
          end else begin
            cand_row_nxt = low_index(fs);
            cand_col_nxt = low_index(col);
            // A single agreeing sample already satisfies a threshold of one
            if (DEBOUNCE_CNT == 1) begin
              state_nxt    = ST_HELD;
              posicion_nxt = {low_index(fs), low_index(col)};
              strobe_nxt   = 1'b1;
              valid_nxt    = 1'b1;
            end else begin
              state_nxt  = ST_DEBOUNCE;
              db_cnt_nxt = DB_ONE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (row_hit) begin
            db_cnt_nxt = db_cnt + DB_ONE;
            if (db_cnt + DB_ONE == DB_DONE) begin
              state_nxt    = ST_HELD;
              posicion_nxt = {cand_row, cand_col};
              strobe_nxt   = 1'b1;
              valid_nxt    = 1'b1;
            end
          end else begin
            state_nxt = ST_SCAN;
            col_nxt   = {col[2:0], col[3]};
          end
        end
        ST_HELD: begin
          if (!row_hit) begin
            if (DEBOUNCE_CNT == 1) begin
              state_nxt = ST_SCAN;
              valid_nxt = 1'b0;
              col_nxt   = {col[2:0], col[3]};
            end else begin
              state_nxt  = ST_RELEASE;
              db_cnt_nxt = DB_ONE;
            end
          end
        end
        default: begin
          if (!row_hit) begin
            db_cnt_nxt = db_cnt + DB_ONE;
            if (db_cnt + DB_ONE == DB_DONE) begin
              state_nxt = ST_SCAN;
              valid_nxt = 1'b0;
              col_nxt   = {col[2:0], col[3]};
            end
          end else begin
            state_nxt = ST_HELD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: directed scenarios plus random row activity,
// each cycle checked against a sample-event level reference model.
module tb_keypad_scan_debounce;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 3;

  logic       clk;
  logic       rst;
  logic [3:0] fila;
  logic [3:0] col;
  logic [3:0] posicion;
  logic       key_strobe;
  logic       key_valid;

  int n_tests;
  int n_fail;
  int dut_strobes;
  logic prev_strobe;

  // Reference model: activity modes 0 idle scan, 1 confirming press, 2 held, 3 confirming release
  int   m_tick;
  logic [3:0] m_s1;
  logic [3:0] m_fs;
  int   m_mode;
  int   m_agree;
  int   m_colidx;
  int   m_row;
  int   m_ccol;
  int   m_pos;
  logic m_strobe;
  logic m_valid;

  keypad_scan_debounce #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fila      (fila),
    .col       (col),
    .posicion  (posicion),
    .key_strobe(key_strobe),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_tick = 0; m_s1 = 4'b0; m_fs = 4'b0;
    m_mode = 0; m_agree = 0; m_colidx = 0;
    m_row = 0; m_ccol = 0; m_pos = 0;
    m_strobe = 1'b0; m_valid = 1'b0;
    prev_strobe = 1'b0;
  endtask

  task automatic model_accept();
    m_pos = m_row * 4 + m_ccol;
    m_strobe = 1'b1;
    m_valid = 1'b1;
    m_mode = 2;
  endtask

  task automatic model_release();
    m_valid = 1'b0;
    m_mode = 0;
    m_colidx = (m_colidx + 1) % 4;
  endtask

  // Advance the model by one clock edge with row value f present at that edge
  task automatic model_step(input logic [3:0] f);
    m_strobe = 1'b0;
    if (m_tick == SCAN_DIV - 1) begin
      case (m_mode)
        0: begin
          if (m_fs == 4'b0) m_colidx = (m_colidx + 1) % 4;
          else begin
            for (int i = 3; i >= 0; i--) if (m_fs[i]) m_row = i;
            m_ccol = m_colidx;
            m_agree = 1;
            if (m_agree >= DEBOUNCE_CNT) model_accept();
            else m_mode = 1;
          end
        end
        1: begin
          if (m_fs[m_row]) begin
            m_agree++;
            if (m_agree >= DEBOUNCE_CNT) model_accept();
          end else begin
            m_mode = 0;
            m_colidx = (m_colidx + 1) % 4;
          end
        end
        2: begin
          if (!m_fs[m_row]) begin
            m_agree = 1;
            if (m_agree >= DEBOUNCE_CNT) model_release();
            else m_mode = 3;
          end
        end
        default: begin
          if (!m_fs[m_row]) begin
            m_agree++;
            if (m_agree >= DEBOUNCE_CNT) model_release();
          end else m_mode = 2;
        end
      endcase
    end
    m_fs = m_s1;
    m_s1 = f;
    m_tick = (m_tick + 1) % SCAN_DIV;
  endtask

  // One clock with row value f, then compare every output against the model
  task automatic cycle(input logic [3:0] f);
    logic [9:0] exp_v;
    logic [9:0] got_v;
    fila = f;
    @(posedge clk);
    model_step(f);
    #1;
    exp_v = {4'(1 << m_colidx), 4'(m_pos), m_strobe, m_valid};
    got_v = {col, posicion, key_strobe, key_valid};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle t=%0t got col=%b pos=%0d stb=%b vld=%b expected col=%b pos=%0d stb=%b vld=%b",
               $time, got_v[9:6], got_v[5:2], got_v[1], got_v[0],
               exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end
    if (key_strobe === 1'b1) dut_strobes++;
    if (key_strobe === 1'b1 && prev_strobe === 1'b1) begin
      n_fail++;
      $display("FAIL strobe_twice t=%0t got two consecutive strobes, required single-cycle", $time);
    end
    prev_strobe = key_strobe;
  endtask

  task automatic wait_col(input logic [3:0] target);
    for (int i = 0; i < 40 && 4'(1 << m_colidx) !== target; i++) cycle(4'b0000);
    n_tests++;
    if (col !== target) begin
      n_fail++;
      $display("FAIL wait_col got %b required %b", col, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fila = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({col, posicion, key_strobe, key_valid} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset got col=%b pos=%0d stb=%b vld=%b required 0001/0/0/0",
               col, posicion, key_strobe, key_valid);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_scan_idle();
    int changes;
    logic [3:0] last;
    changes = 0;
    dut_strobes = 0;
    last = col;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0000);
      if (col !== last) changes++;
      last = col;
    end
    n_tests++;
    if (changes != 10 || dut_strobes != 0 || posicion !== 4'd0) begin
      n_fail++;
      $display("FAIL scan_idle got changes=%0d strobes=%0d pos=%0d required 10/0/0",
               changes, dut_strobes, posicion);
    end
  endtask

  task automatic test_press();
    wait_col(4'b0010);
    dut_strobes = 0;
    repeat (16) cycle(4'b0100);
    n_tests++;
    if (dut_strobes != 1 || posicion !== 4'd9 || key_valid !== 1'b1 || col !== 4'b0010) begin
      n_fail++;
      $display("FAIL press got strobes=%0d pos=%0d vld=%b col=%b required 1/9/1/0010",
               dut_strobes, posicion, key_valid, col);
    end
  endtask

  task automatic test_release();
    logic [3:0] col_at_drop;
    logic       valid_dropped;
    col_at_drop = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0000);
      if (key_valid === 1'b0 && col_at_drop == 4'b0000) col_at_drop = col;
    end
    n_tests++;
    if (key_valid !== 1'b0 || col_at_drop !== 4'b0100 || posicion !== 4'd9) begin
      n_fail++;
      $display("FAIL release got vld=%b col_at_drop=%b pos=%0d required 0/0100/9",
               key_valid, col_at_drop, posicion);
    end
    // Re-press, then a one-sample low glitch while held
    repeat (16) cycle(4'b0100);
    dut_strobes = 0;
    valid_dropped = 1'b0;
    repeat (SCAN_DIV) begin
      cycle(4'b0000);
      if (key_valid !== 1'b1) valid_dropped = 1'b1;
    end
    repeat (16) begin
      cycle(4'b0100);
      if (key_valid !== 1'b1) valid_dropped = 1'b1;
    end
    n_tests++;
    if (valid_dropped || dut_strobes != 0) begin
      n_fail++;
      $display("FAIL release_glitch got valid_dropped=%b strobes=%0d required 0/0",
               valid_dropped, dut_strobes);
    end
    repeat (20) cycle(4'b0000);
  endtask

  task automatic test_bounce();
    wait_col(4'b0010);
    dut_strobes = 0;
    repeat (SCAN_DIV) cycle(4'b0100);
    repeat (SCAN_DIV) cycle(4'b0000);
    n_tests++;
    if (dut_strobes != 0 || col !== 4'b0100 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce got strobes=%0d col=%b vld=%b required 0/0100/0",
               dut_strobes, col, key_valid);
    end
  endtask

  task automatic test_multi_row();
    wait_col(4'b0001);
    dut_strobes = 0;
    repeat (16) cycle(4'b1010);
    n_tests++;
    if (dut_strobes != 1 || posicion !== 4'd4 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_row got strobes=%0d pos=%0d vld=%b required 1/4/1",
               dut_strobes, posicion, key_valid);
    end
    repeat (20) cycle(4'b0000);
  endtask

  task automatic test_reset_mid();
    repeat (8) cycle(4'b0100);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({col, posicion, key_strobe, key_valid} !== {4'b0001, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid got col=%b pos=%0d stb=%b vld=%b required 0001/0/0/0",
               col, posicion, key_strobe, key_valid);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    dut_strobes = 0;
    repeat (20) cycle(4'b0100);
    n_tests++;
    if (dut_strobes != 1 || posicion !== 4'd8 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_redetect got strobes=%0d pos=%0d vld=%b required 1/8/1",
               dut_strobes, posicion, key_valid);
    end
    repeat (20) cycle(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] f;
    int len;
    f = 4'b0000;
    repeat (60) begin
      case ($urandom_range(0, 3))
        0: f = 4'b0000;
        1: f = 4'(1 << $urandom_range(0, 3));
        2: f = 4'($urandom_range(0, 15));
        default: ;
      endcase
      len = $urandom_range(1, 30);
      repeat (len) cycle(f);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    dut_strobes = 0;
    prev_strobe = 1'b0;
    fila = 4'b0000;
    model_reset();
    test_reset();
    test_scan_idle();
    test_press();
    test_release();
    test_bounce();
    test_multi_row();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
